// File: rtl/bias_add_relu_layer9_if.sv
// Stream bundle between the adder tree, the bias/ReLU requantizer and the
// activation sink. The master side feeds sums and consumes activations.
interface bias_add_relu_layer9_if #(
  parameter int N_adder_tree = 16
);
  logic [N_adder_tree*18-1:0] acc_in;
  logic [N_adder_tree*18-1:0] bias;
  logic                       in_valid;
  logic                       in_ready;
  logic [N_adder_tree*8-1:0]  act_out;
  logic                       out_valid;
  logic                       out_ready;
  logic                       layer_done;
  logic                       sat_flag;

  modport master (
    output acc_in, bias, in_valid, out_ready,
    input  in_ready, act_out, out_valid, layer_done, sat_flag
  );

  modport slave (
    input  acc_in, bias, in_valid, out_ready,
    output in_ready, act_out, out_valid, layer_done, sat_flag
  );
endinterface

// File: rtl/bias_add_relu_layer9.sv
// Two-stage per-lane bias add (18-bit saturating) followed by ReLU with
// round-half-up requantization to u8; counts vectors to flag end of layer.
module bias_add_relu_lane #(
  parameter int SHIFT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld1_i,
  input  logic        ld2_i,
  input  logic [17:0] acc_i,
  input  logic [17:0] bias_i,
  output logic [7:0]  act_o,
  output logic        sat_o
);
  logic [18:0] sum;
  logic        clamp1, clamp2, pos;
  logic [17:0] s1_d, s1_q;
  logic [18:0] rnd, r;
  logic [7:0]  act_d, act_q;

  always_comb begin
    sum    = {acc_i[17], acc_i} + {bias_i[17], bias_i};
    // Overflow out of 18 bits shows up as the two top bits disagreeing.
    clamp1 = sum[18] ^ sum[17];
    s1_d   = clamp1 ? {sum[18], {17{~sum[18]}}} : sum[17:0];
    pos    = !s1_q[17] && (|s1_q[16:0]);
    rnd    = {2'b00, s1_q[16:0]} + (19'd1 << (SHIFT - 1));
    r      = rnd >> SHIFT;
    clamp2 = pos && (|r[18:8]);
    act_d  = !pos ? 8'd0 : (clamp2 ? 8'hFF : r[7:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= '0;
      act_q <= '0;
    end else begin
      if (ld1_i) s1_q  <= s1_d;
      if (ld2_i) act_q <= act_d;
    end
  end

  assign act_o = act_q;
  assign sat_o = (ld1_i && clamp1) || (ld2_i && clamp2);
endmodule

module bias_add_relu_layer9 #(
  parameter int N_adder_tree = 16,
  parameter int SHIFT        = 8,
  parameter int N_VECTORS    = 196
) (
  input logic                  clk,
  input logic                  rst,
  bias_add_relu_layer9_if.slave io
);
  localparam int STAGES = 2;
  localparam logic [15:0] LAST = 16'(N_VECTORS - 1);

  logic [STAGES:1]           vld_pipe_q;
  logic                      en1, en2, ld1, ld2, out_fire;
  logic [N_adder_tree-1:0]   lane_sat;
  logic [15:0]               vec_cnt_q, vec_cnt_d;
  logic                      done_q, sat_q;

  assign en2      = !vld_pipe_q[2] || io.out_ready;
  assign en1      = !vld_pipe_q[1] || en2;
  assign ld1      = en1 && io.in_valid;
  assign ld2      = en2 && vld_pipe_q[1];
  assign out_fire = vld_pipe_q[2] && io.out_ready;

  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    bias_add_relu_lane #(.SHIFT(SHIFT)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .ld1_i  (ld1),
      .ld2_i  (ld2),
      .acc_i  (io.acc_in[18*i +: 18]),
      .bias_i (io.bias[18*i +: 18]),
      .act_o  (io.act_out[8*i +: 8]),
      .sat_o  (lane_sat[i])
    );
  end

  always_comb begin
    vec_cnt_d = vec_cnt_q;
    if (out_fire) vec_cnt_d = (vec_cnt_q == LAST) ? 16'd0 : vec_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      vec_cnt_q  <= '0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      if (en1) vld_pipe_q[1] <= io.in_valid;
      if (en2) vld_pipe_q[2] <= vld_pipe_q[1];
      vec_cnt_q <= vec_cnt_d;
      done_q    <= out_fire && (vec_cnt_q == LAST);
      sat_q     <= sat_q || (|lane_sat);
    end
  end

  // Reset forces the handshake to "accept and discard" with nothing offered.
  assign io.in_ready   = en1 || rst;
  assign io.out_valid  = vld_pipe_q[2] && !rst;
  assign io.layer_done = done_q;
  assign io.sat_flag   = sat_q;
endmodule

// File: tb/tb_bias_add_relu_layer9.sv
// Directed bench: per-vector table, then streaming, layer-count and reset sequences.
module tb_bias_add_relu_layer9;
  localparam int NL = 4;

  typedef struct {
    logic [NL-1:0][17:0] acc;
    logic [NL-1:0][17:0] bias;
    logic [NL-1:0][7:0]  act;
    logic                sat;
  } vec_t;

  logic clk, rst;
  int total, bad, hs_total;
  vec_t tbl[7];

  bias_add_relu_layer9_if #(.N_adder_tree(NL)) bus ();
  bias_add_relu_layer9 #(.N_adder_tree(NL), .SHIFT(8), .N_VECTORS(4)) dut (
    .clk(clk), .rst(rst), .io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input int a0, a1, a2, a3, b0, b1, b2, b3,
                              e0, e1, e2, e3, input bit s);
    vec_t v;
    v.acc  = {18'(a3), 18'(a2), 18'(a1), 18'(a0)};
    v.bias = {18'(b3), 18'(b2), 18'(b1), 18'(b0)};
    v.act  = {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    v.sat  = s;
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 with reset released.
  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    hs_total = 0;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    do_reset();
    bus.bias = v.bias; bus.acc_in = v.acc;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1 chk($sformatf("v%0d in_ready", k), bus.in_ready, 1);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    chk($sformatf("v%0d early_valid", k), bus.out_valid, 0);
    @(posedge clk); #1;
    chk($sformatf("v%0d out_valid", k), bus.out_valid, 1);
    chk($sformatf("v%0d act", k), bus.act_out, v.act);
    chk($sformatf("v%0d sat", k), bus.sat_flag, v.sat);
    @(posedge clk); #1;
    chk($sformatf("v%0d no_dup", k), bus.out_valid, 0);
  endtask

  // 5 vectors against out_ready pattern 1,0,0,1 with an occupancy model.
  task automatic stream_toggle();
    logic [NL-1:0][7:0]  q[$];
    logic [NL-1:0][17:0] a;
    logic [NL-1:0][7:0]  e, held;
    bit m1, m2, stalled, acc_ok, en1, en2;
    int sent, got;
    do_reset();
    bus.bias = '0; sent = 0; got = 0; m1 = 0; m2 = 0; stalled = 0; held = '0;
    for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
      bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      bus.in_valid  = (sent < 5);
      a = '0; a[0] = 18'(256 * (sent + 1)); a[1] = 18'(256 * (sent + 10));
      bus.acc_in = a;
      @(negedge clk);
      chk("str in_ready", bus.in_ready, !(m1 && m2 && !bus.out_ready));
      chk("str out_valid", bus.out_valid, m2);
      if (stalled) chk("str hold", bus.act_out, held);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("str extra_out", 1, 0);
        else chk("str order", bus.act_out, q.pop_front());
        got++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      held = bus.act_out;
      en2 = !m2 || bus.out_ready;
      en1 = !m1 || en2;
      acc_ok = en1 && bus.in_valid;
      if (acc_ok) begin
        e = '0; e[0] = 8'(sent + 1); e[1] = 8'(sent + 10);
        q.push_back(e); sent++;
      end
      if (en2) m2 = m1;
      if (en1) m1 = bus.in_valid;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("str received", got, 5);
    chk("str sent", sent, 5);
  endtask

  // n back-to-back vectors; layer_done expected one cycle after every 4th handshake.
  task automatic stream_n(input int n, input int exp_pulses);
    bit exp_done;
    int pulses, hs;
    exp_done = 0; pulses = 0; hs = 0;
    bus.bias = '0; bus.acc_in = '0; bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < n + 6; cyc++) begin
      bus.in_valid = (cyc < n);
      @(negedge clk);
      chk($sformatf("done c%0d", cyc), bus.layer_done, exp_done);
      pulses += int'(bus.layer_done);
      exp_done = 0;
      if (bus.out_valid && bus.out_ready) begin
        hs++; hs_total++;
        exp_done = (hs_total % 4 == 0);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("done handshakes", hs, n);
    chk("done pulses", pulses, exp_pulses);
  endtask

  task automatic reset_midflight();
    logic [NL-1:0][17:0] a, b;
    logic [NL-1:0][7:0]  e;
    do_reset();
    b = '0; b[0] = 18'd6172; b[1] = 18'd6172; bus.bias = b;
    a = '0; a[0] = 18'd131071; bus.acc_in = a;
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1 bus.acc_in = '0;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    chk("rst full out_valid", bus.out_valid, 1);
    chk("rst full in_ready", bus.in_ready, 0);
    chk("rst full sat", bus.sat_flag, 1);
    rst = 1'b1; bus.in_valid = 1'b1; bus.acc_in = a;
    #1 chk("rst during in_ready", bus.in_ready, 1);
    chk("rst during out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst layer_done", bus.layer_done, 0);
    chk("rst sat", bus.sat_flag, 0);
    chk("rst act", bus.act_out, 0);
    chk("rst in_ready", bus.in_ready, 1);
    rst = 1'b0; bus.acc_in = '0; bus.out_ready = 1'b1;
    #1 chk("first in_ready", bus.in_ready, 1);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    chk("first early", bus.out_valid, 0);
    @(posedge clk); #1;
    e = '0; e[0] = 8'd24; e[1] = 8'd24;
    chk("first out_valid", bus.out_valid, 1);
    chk("first act", bus.act_out, e);
    chk("first sat", bus.sat_flag, 0);
    @(posedge clk); #1;
    chk("first no_dup", bus.out_valid, 0);
    hs_total = 1;
    stream_n(3, 1);
  endtask

  initial begin
    total = 0; bad = 0; hs_total = 0;
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.acc_in = '0; bus.bias = '0;
    tbl[0] = mk(0, 0, 16960, 0,  -16704, 6172, -16704, 0,  0, 24, 1, 0,  0);
    tbl[1] = mk(131071, 0, 0, 0,  6172, 0, 0, 0,  255, 0, 0, 0,  1);
    tbl[2] = mk(-131072, 0, 0, 0,  -5, 0, 0, 0,  0, 0, 0, 0,  1);
    tbl[3] = mk(65535, 0, 0, 0,  0, 0, 0, 0,  255, 0, 0, 0,  1);
    tbl[4] = mk(-1, 65407, 127, 128,  1, 0, 0, 0,  0, 255, 0, 1,  0);
    tbl[5] = mk(383, 384, 100000, 131071,  0, 0, -99000, -131072,  1, 2, 4, 0,  0);
    tbl[6] = mk(-131072, 65000, 1, 200,  0, -65000, 0, -72,  0, 0, 0, 1,  0);
    @(posedge clk); #1;
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset act", bus.act_out, 0);
    chk("reset sat", bus.sat_flag, 0);
    chk("reset done", bus.layer_done, 0);
    for (int k = 0; k < 7; k++) run_vec(k, tbl[k]);
    stream_toggle();
    do_reset();
    stream_n(8, 2);
    stream_n(4, 1);
    reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
